// File: rtl/bcd_scan_counter.sv
// Purpose : DIGITS-wide BCD up/down counter with a prescaled tick, plus a
//           multiplexed active-low seven-segment scanner for the same count.
// Latency : count/wrap visible one cycle after the tick/clr/load edge; display
//           registers lag the scan index and count by one cycle.
// Backpressure: none; free-running. en holds the count, the scanner never stalls.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   en, up, clr, load    run/hold, direction, sync clear, sync parallel load
//   load_val[4*DIGITS]   BCD load value, digit i at [4i+3:4i]
//   dp_in[DIGITS]        per-digit decimal point (active-low)
//   count, wrap          registered BCD count, one-cycle wrap pulse
//   seg_out, dp_out, an  registered segment/dp/anode drives (all active-low)
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    // A one-digit display still needs a 1-bit index vector.
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and count
    // ------------------------------------------------------------------
    logic [PW-1:0]        presc;
    logic                 tick;
    logic [4*DIGITS-1:0]  inc_val;
    logic [4*DIGITS-1:0]  dec_val;
    logic [4*DIGITS-1:0]  load_sat;
    logic                 all9;
    logic                 all0;
    logic                 carry;
    logic                 borrow;
    logic [3:0]           nib;

    assign tick = en && (presc == P_LAST);

    // Ripple the carry/borrow from digit 0 upward. The count only ever holds
    // legal BCD because loads are saturated, so nib>=9 means exactly 9.
    always_comb begin
        inc_val  = count;
        dec_val  = count;
        load_sat = load_val;
        all9     = 1'b1;
        all0     = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count[4*i +: 4];
            if (nib != 4'd9) all9 = 1'b0;
            if (nib != 4'd0) all0 = 1'b0;
            if (carry) begin
                if (nib >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (nib == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count <= '0;
                presc <= '0;
            end else if (load) begin
                count <= load_sat;
                presc <= '0;
            end else if (en) begin
                if (tick) begin
                    presc <= '0;
                    if (up) begin
                        count <= inc_val;
                        wrap  <= all9;
                    end else begin
                        count <= dec_val;
                        wrap  <= all0;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanner: free-running, ignores en/clr/load
    // ------------------------------------------------------------------
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == S_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == I_LAST) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Display select. Walking from the top digit down, hi_zero records whether
    // every digit at or above i is zero; captured at the lit digit it decides
    // leading-zero blanking.
    // ------------------------------------------------------------------
    logic [3:0]        cur_dig;
    logic              cur_dp;
    logic              cur_lz;
    logic              hi_zero;
    logic              blank;
    logic [DIGITS-1:0] an_nxt;

    always_comb begin
        cur_dig = 4'd0;
        cur_dp  = 1'b1;
        cur_lz  = 1'b0;
        hi_zero = 1'b1;
        an_nxt  = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count[4*i +: 4] != 4'd0) hi_zero = 1'b0;
            if (idx == IW'(i)) begin
                cur_dig   = count[4*i +: 4];
                cur_dp    = dp_in[i];
                cur_lz    = hi_zero;
                an_nxt[i] = 1'b0;
            end
        end
        blank = (BLANK_LZ != 0) && (idx != '0) && cur_lz;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
            an      <= '1;
        end else begin
            seg_out <= blank ? SEG_BLANK : seg_decode(cur_dig);
            dp_out  <= cur_dp;
            an      <= an_nxt;
        end
    end

endmodule
